// File: rtl/spi_slave_wb_bridge_pkg.sv
// Shared definitions for the SPI-to-Wishbone bridge: FSM encoding,
// command byte layout, frame lengths and the read error word.
package spi_slave_wb_bridge_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE    = 3'd0;
   localparam state_t ST_CMD     = 3'd1;
   localparam state_t ST_WDATA   = 3'd2;
   localparam state_t ST_WB_WR   = 3'd3;
   localparam state_t ST_RDUMMY  = 3'd4;
   localparam state_t ST_RDATA   = 3'd5;
   localparam state_t ST_WAIT_SS = 3'd6;

   // Command byte: {RW, 1'b0, IDX[5:0]}; RW=1 is a write.
   localparam int CMD_RW_BIT  = 7;
   localparam int CMD_IDX_MSB = 5;

   // Bit counts (SCLK rising edges) that mark frame milestones.
   localparam logic [5:0] CMD_LEN      = 6'd8;
   localparam logic [5:0] RD_DUMMY_END = 6'd16;
   localparam logic [5:0] FRAME_WR_LEN = 6'd40;
   localparam logic [5:0] FRAME_RD_LEN = 6'd48;

   // Returned on a failed or late read.
   localparam logic [31:0] ERR_WORD = 32'hFFFF_FFFF;

   // Word index lands in address bits [7:2].
   function automatic logic [31:0] word_adr(input logic [31:0] base,
                                            input logic [5:0]  idx);
      return base | {24'h0, idx, 2'b00};
   endfunction

endpackage

// File: rtl/spi_slave_wb_bridge_if.sv
// Wishbone master-side bundle of the bridge plus its error interrupt.
// Handshake: a cycle is open while CYC and STB are high; address, data,
// WE and SEL are stable for the whole cycle; the slave ends it by raising
// ACK or ERR for one clock (ERR wins if both are high) and the master
// drops CYC/STB on the following clock.
interface spi_slave_wb_bridge_if;
   logic [31:0] SPIB_ADR_O;
   logic [31:0] SPIB_DAT_O;
   logic [31:0] SPIB_DAT_I;
   logic        SPIB_WE_O;
   logic        SPIB_CYC_O;
   logic        SPIB_STB_O;
   logic [3:0]  SPIB_SEL_O;
   logic        SPIB_ACK_I;
   logic        SPIB_ERR_I;
   logic        SPIB_INT_O;

   modport master (
      output SPIB_ADR_O, SPIB_DAT_O, SPIB_WE_O, SPIB_CYC_O, SPIB_STB_O,
             SPIB_SEL_O, SPIB_INT_O,
      input  SPIB_DAT_I, SPIB_ACK_I, SPIB_ERR_I
   );

   modport slave (
      input  SPIB_ADR_O, SPIB_DAT_O, SPIB_WE_O, SPIB_CYC_O, SPIB_STB_O,
             SPIB_SEL_O, SPIB_INT_O,
      output SPIB_DAT_I, SPIB_ACK_I, SPIB_ERR_I
   );
endinterface

// File: rtl/spi_slave_wb_bridge_sync.sv
// Brings SCLK, SS_N and MOSI into the system clock domain and produces
// single-cycle rise/fall strobes for SCLK and SS_N.
module spi_slave_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic sclk_in,
   input  logic ss_n_in,
   input  logic mosi_in,
   output logic sclk_rise,
   output logic sclk_fall,
   output logic ss_n,
   output logic ss_n_fall,
   output logic ss_n_rise,
   output logic mosi
);
   // [1] is the synchronized value, [2] its previous value for edge detect.
   logic [2:0] sclk_q;
   logic [2:0] ss_q;
   logic [1:0] mosi_q;

   // Synchronizer chains; SS_N resets to deselected so no false edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_q <= 3'b000;
         ss_q   <= 3'b111;
         mosi_q <= 2'b00;
      end else begin
         sclk_q <= {sclk_q[1:0], sclk_in};
         ss_q   <= {ss_q[1:0], ss_n_in};
         mosi_q <= {mosi_q[0], mosi_in};
      end
   end

   assign sclk_rise = sclk_q[1] & ~sclk_q[2];
   assign sclk_fall = ~sclk_q[1] & sclk_q[2];
   assign ss_n      = ss_q[1];
   assign ss_n_fall = ~ss_q[1] & ss_q[2];
   assign ss_n_rise = ss_q[1] & ~ss_q[2];
   assign mosi      = mosi_q[1];

endmodule

// File: rtl/spi_slave_wb_bridge.sv
// SPI mode-0 responder turning each framed register access into one
// 32-bit Wishbone cycle. Write frame: cmd + 32 data bits. Read frame:
// cmd + 8 dummy bits (bus read runs meanwhile) + 32 data bits on MISO.
module spi_slave_wb_bridge
   import spi_slave_wb_bridge_pkg::*;
#(
   parameter logic [31:0] BASE_ADR   = 32'h8000_0000,
   parameter int          WB_TIMEOUT = 255
) (
   input  logic                         CLK_I,
   input  logic                         RST_N_I,
   input  logic                         SCLK_SLAVE,
   input  logic                         SS_N_SLAVE,
   input  logic                         MOSI_SLAVE,
   output logic                         MISO_SLAVE,
   output logic                         MISO_OE_O,
   spi_slave_wb_bridge_if.master        spib,
   output state_t                       dbg_state
);
   localparam int TW = $clog2(WB_TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(WB_TIMEOUT - 1);

   logic s_sclk_rise, s_sclk_fall, s_ss_n, s_ss_n_fall, s_ss_n_rise, s_mosi;

   spi_slave_sync u_sync (
      .clk       (CLK_I),
      .rst_n     (RST_N_I),
      .sclk_in   (SCLK_SLAVE),
      .ss_n_in   (SS_N_SLAVE),
      .mosi_in   (MOSI_SLAVE),
      .sclk_rise (s_sclk_rise),
      .sclk_fall (s_sclk_fall),
      .ss_n      (s_ss_n),
      .ss_n_fall (s_ss_n_fall),
      .ss_n_rise (s_ss_n_rise),
      .mosi      (s_mosi)
   );

   state_t        state;
   logic [5:0]    bit_cnt;
   logic [5:0]    cnt_next;
   logic [30:0]   rx_sr;
   logic [31:0]   tx_sr;
   logic [31:0]   rd_buf;
   logic [5:0]    idx;
   logic [7:0]    cmd_byte;
   logic          rise_bit;
   logic          start_wr;
   logic          start_rd;
   logic          cyc;
   logic          we;
   logic [31:0]   adr;
   logic [31:0]   dat;
   logic          int_p;
   logic [TW-1:0] timer;

   // A deselect on the same clock as an SCLK edge wins: the bit is dropped.
   assign rise_bit = s_sclk_rise & ~s_ss_n_rise;
   assign cnt_next = bit_cnt + 6'd1;
   assign cmd_byte = {rx_sr[6:0], s_mosi};
   assign start_wr = (state == ST_WDATA) && rise_bit && (cnt_next == FRAME_WR_LEN);
   assign start_rd = (state == ST_CMD) && rise_bit && (cnt_next == CMD_LEN)
                     && !cmd_byte[CMD_RW_BIT];

   // Frame sequencer: bit counting, MOSI capture, MISO shifting.
   always_ff @(posedge CLK_I or negedge RST_N_I) begin
      if (!RST_N_I) begin
         state      <= ST_IDLE;
         bit_cnt    <= 6'd0;
         rx_sr      <= '0;
         tx_sr      <= '0;
         idx        <= 6'd0;
         MISO_SLAVE <= 1'b0;
      end else begin
         if (state == ST_RDATA && s_sclk_fall) begin
            MISO_SLAVE <= tx_sr[31];
            tx_sr      <= {tx_sr[30:0], 1'b0};
         end else if (state != ST_RDATA) begin
            MISO_SLAVE <= 1'b0;
         end

         if (state != ST_IDLE && s_ss_n_rise) begin
            state   <= ST_IDLE;
            bit_cnt <= 6'd0;
         end else begin
            case (state)
               ST_IDLE: begin
                  // A select arriving while a bus cycle drains is dropped.
                  if (s_ss_n_fall && !cyc) begin
                     state   <= ST_CMD;
                     bit_cnt <= 6'd0;
                  end
               end
               ST_CMD: begin
                  if (rise_bit) begin
                     bit_cnt <= cnt_next;
                     rx_sr   <= {rx_sr[29:0], s_mosi};
                     if (cnt_next == CMD_LEN) begin
                        idx   <= cmd_byte[CMD_IDX_MSB:0];
                        state <= cmd_byte[CMD_RW_BIT] ? ST_WDATA : ST_RDUMMY;
                     end
                  end
               end
               ST_WDATA: begin
                  if (rise_bit) begin
                     bit_cnt <= cnt_next;
                     rx_sr   <= {rx_sr[29:0], s_mosi};
                     if (cnt_next == FRAME_WR_LEN) state <= ST_WB_WR;
                  end
               end
               ST_WB_WR: begin
                  if (!cyc) state <= ST_WAIT_SS;
               end
               ST_RDUMMY: begin
                  if (rise_bit) begin
                     bit_cnt <= cnt_next;
                     if (cnt_next == RD_DUMMY_END) begin
                        tx_sr <= rd_buf;
                        state <= ST_RDATA;
                     end
                  end
               end
               ST_RDATA: begin
                  if (rise_bit) begin
                     bit_cnt <= cnt_next;
                     if (cnt_next == FRAME_RD_LEN) state <= ST_WAIT_SS;
                  end
               end
               ST_WAIT_SS: ;
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   // Wishbone master: one cycle per frame, ERR beats ACK, bounded wait.
   always_ff @(posedge CLK_I or negedge RST_N_I) begin
      if (!RST_N_I) begin
         cyc    <= 1'b0;
         we     <= 1'b0;
         adr    <= '0;
         dat    <= '0;
         int_p  <= 1'b0;
         timer  <= '0;
         rd_buf <= ERR_WORD;
      end else begin
         int_p <= 1'b0;
         if (cyc) begin
            if (spib.SPIB_ERR_I) begin
               cyc   <= 1'b0;
               we    <= 1'b0;
               int_p <= 1'b1;
            end else if (spib.SPIB_ACK_I) begin
               cyc <= 1'b0;
               we  <= 1'b0;
               if (!we) rd_buf <= spib.SPIB_DAT_I;
            end else if (timer == TMO_LAST) begin
               cyc   <= 1'b0;
               we    <= 1'b0;
               int_p <= 1'b1;
            end else begin
               timer <= timer + 1'b1;
            end
         end else if (start_wr) begin
            cyc   <= 1'b1;
            we    <= 1'b1;
            adr   <= word_adr(BASE_ADR, idx);
            dat   <= {rx_sr, s_mosi};
            timer <= '0;
         end else if (start_rd) begin
            cyc    <= 1'b1;
            we     <= 1'b0;
            adr    <= word_adr(BASE_ADR, cmd_byte[CMD_IDX_MSB:0]);
            timer  <= '0;
            rd_buf <= ERR_WORD;
         end
      end
   end

   // Pad enable follows the synchronized select.
   always_ff @(posedge CLK_I or negedge RST_N_I) begin
      if (!RST_N_I) MISO_OE_O <= 1'b0;
      else          MISO_OE_O <= ~s_ss_n;
   end

   assign spib.SPIB_CYC_O = cyc;
   assign spib.SPIB_STB_O = cyc;
   assign spib.SPIB_WE_O  = we;
   assign spib.SPIB_ADR_O = adr;
   assign spib.SPIB_DAT_O = dat;
   assign spib.SPIB_SEL_O = cyc ? 4'hF : 4'h0;
   assign spib.SPIB_INT_O = int_p;
   assign dbg_state       = state;

endmodule

// File: tb/tb_spi_slave_wb_bridge.sv
// Directed bench for spi_slave_wb_bridge: drives SPI frames as a mode-0
// master, models a Wishbone slave with selectable termination, and checks
// bus transactions, MISO data and interrupt pulses.
module tb_spi_slave_wb_bridge;

   localparam int HP = 5;   // SPI half period in CLK_I cycles

   logic        clk;
   logic        rst_n;
   logic        sclk;
   logic        ss_n;
   logic        mosi;
   logic        miso;
   logic        miso_oe;
   logic [2:0]  dbg_state;

   spi_slave_wb_bridge_if bus ();

   spi_slave_wb_bridge #(
      .BASE_ADR   (32'h8000_0000),
      .WB_TIMEOUT (16)
   ) dut (
      .CLK_I      (clk),
      .RST_N_I    (rst_n),
      .SCLK_SLAVE (sclk),
      .SS_N_SLAVE (ss_n),
      .MOSI_SLAVE (mosi),
      .MISO_SLAVE (miso),
      .MISO_OE_O  (miso_oe),
      .spib       (bus),
      .dbg_state  (dbg_state)
   );

   // ---------------- clock ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- counters ----------------
   int n_cmp;
   int n_err;

   function automatic void check(input string name, input logic [31:0] act,
                                 input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endfunction

   // ---------------- Wishbone slave model ----------------
   // mode 0: ACK, 1: ERR, 2: no reply, 3: ACK and ERR together
   int          s_mode;
   int          s_delay;
   logic [31:0] s_rdata;
   int          wb_cycles;
   int          cyc_hi_cnt;
   logic [31:0] cap_adr;
   logic [31:0] cap_dat;
   logic        cap_we;
   logic [3:0]  cap_sel;
   int          int_cnt;

   initial begin
      bus.SPIB_ACK_I = 1'b0;
      bus.SPIB_ERR_I = 1'b0;
      bus.SPIB_DAT_I = '0;
      wb_cycles = 0;
      cyc_hi_cnt = 0;
      forever begin
         @(negedge clk);
         if (bus.SPIB_CYC_O && bus.SPIB_STB_O) begin
            wb_cycles++;
            cap_adr = bus.SPIB_ADR_O;
            cap_dat = bus.SPIB_DAT_O;
            cap_we  = bus.SPIB_WE_O;
            cap_sel = bus.SPIB_SEL_O;
            cyc_hi_cnt = 1;
            if (s_mode != 2) begin
               for (int i = 1; i < s_delay; i++) begin
                  @(negedge clk);
                  if (bus.SPIB_CYC_O) cyc_hi_cnt++;
               end
               bus.SPIB_DAT_I = s_rdata;
               bus.SPIB_ACK_I = (s_mode == 0 || s_mode == 3);
               bus.SPIB_ERR_I = (s_mode == 1 || s_mode == 3);
               @(negedge clk);
               bus.SPIB_ACK_I = 1'b0;
               bus.SPIB_ERR_I = 1'b0;
               bus.SPIB_DAT_I = '0;
            end
            for (int i = 0; i < 1000 && bus.SPIB_CYC_O; i++) begin
               @(negedge clk);
               if (bus.SPIB_CYC_O) cyc_hi_cnt++;
            end
         end
      end
   end

   initial begin
      int_cnt = 0;
      forever begin
         @(negedge clk);
         if (bus.SPIB_INT_O) int_cnt++;
      end
   end

   // ---------------- SPI master driver ----------------
   logic [47:0] rx;
   logic [47:0] tx;

   task automatic spi_frame(input int nbits, input logic [47:0] txd,
                            output logic [47:0] rxd);
      rxd = '0;
      @(negedge clk);
      ss_n = 1'b0;
      repeat (HP) @(negedge clk);
      for (int b = 0; b < nbits; b++) begin
         mosi = txd[47-b];
         repeat (HP) @(negedge clk);
         rxd  = {rxd[46:0], miso};
         sclk = 1'b1;
         repeat (HP) @(negedge clk);
         sclk = 1'b0;
      end
      repeat (HP) @(negedge clk);
      ss_n = 1'b1;
      mosi = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (bus.SPIB_CYC_O && n < 400) begin
         @(negedge clk);
         n++;
      end
      n_cmp++;
      if (bus.SPIB_CYC_O) begin
         n_err++;
         $display("FAIL %s idle: CYC still high after %0d cycles, required low", name, n);
      end
      repeat (3) @(negedge clk);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [7:0]  cmd;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          mode;
      int          delay;
      logic [31:0] exp_adr;
      logic [31:0] exp_miso;
      int          exp_int;
      int          exp_cyc_len;   // 0: not checked
   } vec_t;

   vec_t vecs[8];

   task automatic run_vec(input int i);
      int w0, i0;
      s_mode  = vecs[i].mode;
      s_delay = vecs[i].delay;
      s_rdata = vecs[i].rdata;
      w0 = wb_cycles;
      i0 = int_cnt;
      if (vecs[i].cmd[7])
         spi_frame(40, {vecs[i].cmd, vecs[i].wdata, 8'h00}, rx);
      else
         spi_frame(48, {vecs[i].cmd, 40'h0}, rx);
      wait_idle($sformatf("v%0d", i));
      check($sformatf("v%0d wb_cycles", i), wb_cycles - w0, 1);
      check($sformatf("v%0d adr", i), cap_adr, vecs[i].exp_adr);
      check($sformatf("v%0d we", i), {31'h0, cap_we}, {31'h0, vecs[i].cmd[7]});
      check($sformatf("v%0d sel", i), {28'h0, cap_sel}, 32'hF);
      if (vecs[i].cmd[7]) begin
         check($sformatf("v%0d dat_o", i), cap_dat, vecs[i].wdata);
      end else begin
         check($sformatf("v%0d miso_data", i), rx[31:0], vecs[i].exp_miso);
         check($sformatf("v%0d miso_head", i), {16'h0, rx[47:32]}, 32'h0);
      end
      check($sformatf("v%0d int_pulses", i), int_cnt - i0, vecs[i].exp_int);
      if (vecs[i].exp_cyc_len != 0)
         check($sformatf("v%0d cyc_len", i), cyc_hi_cnt, vecs[i].exp_cyc_len);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " miso"},    {31'h0, miso}, 0);
      check({tag, " miso_oe"}, {31'h0, miso_oe}, 0);
      check({tag, " cyc"},     {31'h0, bus.SPIB_CYC_O}, 0);
      check({tag, " stb"},     {31'h0, bus.SPIB_STB_O}, 0);
      check({tag, " we"},      {31'h0, bus.SPIB_WE_O}, 0);
      check({tag, " adr"},     bus.SPIB_ADR_O, 0);
      check({tag, " dat_o"},   bus.SPIB_DAT_O, 0);
      check({tag, " sel"},     {28'h0, bus.SPIB_SEL_O}, 0);
      check({tag, " int"},     {31'h0, bus.SPIB_INT_O}, 0);
      check({tag, " state"},   {29'h0, dbg_state}, 0);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      int w0;
      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b0;
      sclk  = 1'b0;
      ss_n  = 1'b1;
      mosi  = 1'b0;
      s_mode = 0;
      s_delay = 1;
      s_rdata = '0;

      //            cmd    wdata          rdata          md dl exp_adr        exp_miso       int len
      vecs[0] = '{8'h85, 32'h1234_5678, 32'h0,         0, 2, 32'h8000_0014, 32'h0,         0, 0};
      vecs[1] = '{8'h03, 32'h0,         32'hCAFE_F00D, 0, 3, 32'h8000_000C, 32'hCAFE_F00D, 0, 0};
      vecs[2] = '{8'h10, 32'h0,         32'hDEAD_BEEF, 1, 2, 32'h8000_0040, 32'hFFFF_FFFF, 1, 0};
      vecs[3] = '{8'hBF, 32'hA5A5_5A5A, 32'h0,         2, 1, 32'h8000_00FC, 32'h0,         1, 16};
      vecs[4] = '{8'h81, 32'h0F0F_00FF, 32'h0,         0, 1, 32'h8000_0004, 32'h0,         0, 0};
      vecs[5] = '{8'h3F, 32'h0,         32'h0000_0001, 0, 1, 32'h8000_00FC, 32'h0000_0001, 0, 0};
      vecs[6] = '{8'h2A, 32'h0,         32'h1111_1111, 3, 4, 32'h8000_00A8, 32'hFFFF_FFFF, 1, 0};
      vecs[7] = '{8'h20, 32'h0,         32'h7777_7777, 2, 1, 32'h8000_0080, 32'hFFFF_FFFF, 1, 16};

      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      for (int i = 0; i < 8; i++) run_vec(i);

      // Write frame cut after 20 bits must never reach the bus.
      s_mode = 0; s_delay = 2; s_rdata = 32'h0;
      w0 = wb_cycles;
      spi_frame(20, {8'h85, 32'h1234_5678, 8'h00}, rx);
      repeat (30) @(negedge clk);
      check("abort wb_cycles", wb_cycles - w0, 0);
      check("abort state", {29'h0, dbg_state}, 0);

      // Full read right after the aborted frame.
      s_mode = 0; s_delay = 2; s_rdata = 32'h0BAD_CAFE;
      w0 = wb_cycles;
      spi_frame(48, {8'h07, 40'h0}, rx);
      wait_idle("post_abort");
      check("post_abort wb_cycles", wb_cycles - w0, 1);
      check("post_abort adr", cap_adr, 32'h8000_001C);
      check("post_abort miso_data", rx[31:0], 32'h0BAD_CAFE);

      // Reset asserted mid-read while CYC is high.
      s_mode = 2; s_delay = 1;
      tx = {8'h05, 40'h0};
      @(negedge clk);
      ss_n = 1'b0;
      repeat (HP) @(negedge clk);
      for (int b = 0; b < 8; b++) begin
         mosi = tx[47-b];
         repeat (HP) @(negedge clk);
         sclk = 1'b1;
         if (b < 7) begin
            repeat (HP) @(negedge clk);
            sclk = 1'b0;
         end
      end
      begin : wait_cyc
         int n;
         n = 0;
         while (!bus.SPIB_CYC_O && n < 10) begin
            @(negedge clk);
            n++;
         end
      end
      check("midrd oe", {31'h0, miso_oe}, 1);
      check("midrd cyc", {31'h0, bus.SPIB_CYC_O}, 1);
      check("midrd adr", bus.SPIB_ADR_O, 32'h8000_0014);
      #2 rst_n = 1'b0;
      #1;
      check_reset_outputs("async_rst");
      @(negedge clk);
      sclk = 1'b0;
      ss_n = 1'b1;
      mosi = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      // Recovery write after reset.
      s_mode = 0; s_delay = 2;
      w0 = wb_cycles;
      spi_frame(40, {8'h85, 32'h1234_5678, 8'h00}, rx);
      wait_idle("recover");
      check("recover wb_cycles", wb_cycles - w0, 1);
      check("recover adr", cap_adr, 32'h8000_0014);
      check("recover dat_o", cap_dat, 32'h1234_5678);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
